bright_contrast_adj: RTL and testbench

BRIGHT_CONTRAST_ADJ -- requirements
Module: bright_contrast_adj

---
 rtl/bright_contrast_adj.sv | 210 +++++++++++++++++++++
 tb/tb_bright_contrast_adj.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bright_contrast_adj.sv
// bright_contrast_adj: per-channel brightness/contrast adjustment for a video
// stream, 4-cycle fixed latency (subtract, multiply, round+offset, clamp).
//   clk, rst          single clock, synchronous active-high reset
//   contrast_i        unsigned fixed-point gain, COE_FRAC fractional bits
//   brightness_i      signed 16-bit offset added after the gain
//   bypass_i          1 = pixels pass through unmodified
//   di_i/de_i/hs_i/vs_i/dbg_i   input pixel (ch0 in LSBs), controls, tag
//   do_o/de_o/hs_o/vs_o/dbg_o   same, 4 cycles later
//   sat_cnt_o         number of clipped pixels in the previous frame
// Gain/offset/bypass are shadowed and only pick up new inputs on a vs_i
// rising edge, so a frame is always processed with one parameter set.

// Per-channel datapath; stage parameters are supplied already aligned to the
// stage that consumes them.
module bright_contrast_chan #(
  parameter int PIXEL_WIDTH = 8,
  parameter int COE_WIDTH   = 16,
  parameter int COE_FRAC    = 6,
  parameter int PW_P        = PIXEL_WIDTH + COE_WIDTH + 2,
  parameter int YW          = PW_P + 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PIXEL_WIDTH-1:0]     x_i,    // raw pixel, enters stage 1
  input  logic [COE_WIDTH-1:0]       c_i,    // gain travelling with stage 1
  input  logic signed [15:0]         b_i,    // offset travelling with stage 2
  input  logic                       byp_i,  // bypass travelling with stage 3
  output logic [PIXEL_WIDTH-1:0]     y_o,
  output logic                       clip_o  // clamp stage is clipping now
);
  localparam int MID    = 2**(PIXEL_WIDTH-1);
  localparam int MAXV   = 2**PIXEL_WIDTH - 1;
  localparam int HSH    = (COE_FRAC > 0) ? COE_FRAC - 1 : 0;
  localparam int HALF_I = (COE_FRAC > 0) ? 2**HSH : 0;

  logic [PIXEL_WIDTH-1:0]     r_x1, r_x2, r_x3, r_out;
  logic signed [PIXEL_WIDTH:0] r_d;
  logic signed [PW_P-1:0]     r_p, w_p;
  logic signed [YW-1:0]       r_y, w_q, w_y;
  logic                       w_lo, w_hi;

  // Operands sign-extended to the full product width so the product of the
  // largest gain and the most negative centred pixel cannot overflow.
  assign w_p = PW_P'(r_d) * PW_P'($signed({1'b0, c_i}));
  // Round half up, then re-centre and apply the offset at full width.
  assign w_q = (YW'(r_p) + YW'(HALF_I)) >>> COE_FRAC;
  assign w_y = w_q + YW'(MID) + YW'(b_i);

  assign w_lo   = r_y[YW-1];
  assign w_hi   = ~w_lo & (r_y > YW'(MAXV));
  assign clip_o = w_lo | w_hi;
  assign y_o    = r_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x1  <= '0;
      r_x2  <= '0;
      r_x3  <= '0;
      r_d   <= '0;
      r_p   <= '0;
      r_y   <= '0;
      r_out <= '0;
    end else begin
      r_x1  <= x_i;
      r_d   <= $signed({1'b0, x_i}) - (PIXEL_WIDTH+1)'(MID);
      r_x2  <= r_x1;
      r_p   <= w_p;
      r_x3  <= r_x2;
      r_y   <= w_y;
      if (byp_i)     r_out <= r_x3;
      else if (w_lo) r_out <= '0;
      else if (w_hi) r_out <= PIXEL_WIDTH'(MAXV);
      else           r_out <= r_y[PIXEL_WIDTH-1:0];
    end
  end
endmodule

module bright_contrast_adj #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int CH_COUNT     = 3,
  parameter int COE_FRAC     = 6,
  parameter int COE_WIDTH    = 16,
  parameter int DBG_WIDTH    = 16,
  parameter int SATCNT_WIDTH = 24
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [COE_WIDTH-1:0]            contrast_i,
  input  logic signed [15:0]              brightness_i,
  input  logic                            bypass_i,
  input  logic [CH_COUNT*PIXEL_WIDTH-1:0] di_i,
  input  logic                            de_i,
  input  logic                            hs_i,
  input  logic                            vs_i,
  input  logic [DBG_WIDTH-1:0]            dbg_i,
  output logic [CH_COUNT*PIXEL_WIDTH-1:0] do_o,
  output logic                            de_o,
  output logic                            hs_o,
  output logic                            vs_o,
  output logic [DBG_WIDTH-1:0]            dbg_o,
  output logic [SATCNT_WIDTH-1:0]         sat_cnt_o
);
  localparam int PW_P  = PIXEL_WIDTH + COE_WIDTH + 2;
  localparam int YW    = ((PW_P > 17) ? PW_P : 17) + 2;
  localparam int STAGES = 4;
  localparam logic [SATCNT_WIDTH-1:0] CNT_MAX = '1;

  // Active (shadow) parameters and input vs edge detect.
  logic                   r_vs_prev, w_vs_edge;
  logic [COE_WIDTH-1:0]   r_c;
  logic signed [15:0]     r_b;
  logic                   r_byp;

  // Parameters carried alongside the pixel to the stage that uses them.
  logic [COE_WIDTH-1:0]   r_s1_c;
  logic signed [15:0]     r_s1_b, r_s2_b;
  logic                   r_s1_byp, r_s2_byp, r_s3_byp;

  // Control shift registers; index STAGES-1 is the output stage.
  logic [STAGES-1:0]                r_de_pipe, r_hs_pipe, r_vs_pipe;
  logic [STAGES-1:0][DBG_WIDTH-1:0] r_dbg_pipe;

  logic [CH_COUNT-1:0][PIXEL_WIDTH-1:0] w_y;
  logic [CH_COUNT-1:0]                  w_clip;
  logic                                 w_clipped, w_ovs_edge;
  logic [SATCNT_WIDTH-1:0]              r_cnt, r_sat;

  assign w_vs_edge = vs_i & ~r_vs_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_prev <= 1'b0;
      r_c       <= COE_WIDTH'(1) << COE_FRAC;
      r_b       <= '0;
      r_byp     <= 1'b0;
      r_s1_c    <= '0;
      r_s1_b    <= '0;
      r_s2_b    <= '0;
      r_s1_byp  <= 1'b0;
      r_s2_byp  <= 1'b0;
      r_s3_byp  <= 1'b0;
      r_de_pipe <= '0;
      r_hs_pipe <= '0;
      r_vs_pipe <= '0;
      r_dbg_pipe <= '0;
    end else begin
      r_vs_prev <= vs_i;
      // The pixel on the edge cycle is captured with the old values below,
      // since the shadow registers only change at the end of that cycle.
      if (w_vs_edge) begin
        r_c   <= contrast_i;
        r_b   <= brightness_i;
        r_byp <= bypass_i;
      end
      r_s1_c    <= r_c;
      r_s1_b    <= r_b;
      r_s1_byp  <= r_byp;
      r_s2_b    <= r_s1_b;
      r_s2_byp  <= r_s1_byp;
      r_s3_byp  <= r_s2_byp;
      r_de_pipe <= {r_de_pipe[STAGES-2:0], de_i};
      r_hs_pipe <= {r_hs_pipe[STAGES-2:0], hs_i};
      r_vs_pipe <= {r_vs_pipe[STAGES-2:0], vs_i};
      r_dbg_pipe <= {r_dbg_pipe[STAGES-2:0], dbg_i};
    end
  end

  for (genvar g = 0; g < CH_COUNT; g++) begin : g_ch
    bright_contrast_chan #(
      .PIXEL_WIDTH(PIXEL_WIDTH),
      .COE_WIDTH  (COE_WIDTH),
      .COE_FRAC   (COE_FRAC),
      .PW_P       (PW_P),
      .YW         (YW)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .x_i   (di_i[g*PIXEL_WIDTH +: PIXEL_WIDTH]),
      .c_i   (r_s1_c),
      .b_i   (r_s2_b),
      .byp_i (r_s3_byp),
      .y_o   (w_y[g]),
      .clip_o(w_clip[g])
    );
  end

  // Clip statistics are taken at the clamp stage (pipeline index 2) and the
  // frame boundary is the vs edge as it enters the output register.
  assign w_clipped  = r_de_pipe[STAGES-2] & ~r_s3_byp & (|w_clip);
  assign w_ovs_edge = r_vs_pipe[STAGES-2] & ~r_vs_pipe[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_sat <= '0;
    end else if (w_ovs_edge) begin
      r_sat <= r_cnt;
      r_cnt <= SATCNT_WIDTH'(w_clipped);
    end else if (w_clipped && r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign do_o      = w_y;
  assign de_o      = r_de_pipe[STAGES-1];
  assign hs_o      = r_hs_pipe[STAGES-1];
  assign vs_o      = r_vs_pipe[STAGES-1];
  assign dbg_o     = r_dbg_pipe[STAGES-1];
  assign sat_cnt_o = r_sat;
endmodule

// File: tb/tb_bright_contrast_adj.sv
// Scoreboard bench for bright_contrast_adj (default parameters). Stimulus
// pushes the hand-computed expected pixel for every de_i=1 cycle; a monitor
// pops and compares whenever de_o=1.
module tb_bright_contrast_adj;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [15:0]        contrast_i = 16'd64;
  logic signed [15:0] brightness_i = '0;
  logic               bypass_i = 1'b0;
  logic [23:0]        di_i = '0;
  logic               de_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
  logic [15:0]        dbg_i = '0;
  logic [23:0]        do_o;
  logic               de_o, hs_o, vs_o;
  logic [15:0]        dbg_o;
  logic [23:0]        sat_cnt_o;

  bright_contrast_adj dut (
    .clk(clk), .rst(rst), .contrast_i(contrast_i), .brightness_i(brightness_i),
    .bypass_i(bypass_i), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .dbg_i(dbg_i), .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
    .dbg_o(dbg_o), .sat_cnt_o(sat_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] d;
    logic [15:0] tag;
    logic        hs;
    logic        vs;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] tag = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitor: every output pixel must match the oldest outstanding expectation,
  // including its controls and exactly 4 cycles of latency.
  always @(negedge clk) begin
    if (de_o === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pixel actual do=%06h dbg=%0d required none", do_o, dbg_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (do_o !== e.d || dbg_o !== e.tag || hs_o !== e.hs || vs_o !== e.vs ||
            cyc - e.cyc != 4) begin
          errors++;
          $display("FAIL pixel tag %0d actual do=%06h dbg=%0d hs=%b vs=%b lat=%0d required do=%06h dbg=%0d hs=%b vs=%b lat=4",
                   e.tag, do_o, dbg_o, hs_o, vs_o, cyc - e.cyc, e.d, e.tag, e.hs, e.vs);
        end
      end
    end
  end

  task automatic drive(input logic [23:0] d, input logic de, input logic vs,
                       input logic push, input logic [23:0] ex);
    exp_t e;
    logic h;
    h = 1'($urandom_range(0, 1));
    tag++;
    di_i = d; de_i = de; vs_i = vs; hs_i = h; dbg_i = tag;
    if (de && push) begin
      e.d = ex; e.tag = tag; e.hs = h; e.vs = vs; e.cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic step(input logic [23:0] d, input logic de, input logic vs,
                      input logic [23:0] ex);
    @(posedge clk); #1;
    drive(d, de, vs, 1'b1, ex);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(24'h0, 1'b0, 1'b0, 24'h0);
  endtask

  initial begin
    logic [23:0] v;
    int nclip;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_do", 32'(do_o), 32'd0);
    chk("rst_de", 32'(de_o), 32'd0);
    chk("rst_vs", 32'(vs_o), 32'd0);
    chk("rst_hs", 32'(hs_o), 32'd0);
    chk("rst_dbg", 32'(dbg_o), 32'd0);
    chk("rst_sat", 32'(sat_cnt_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Identity after reset (no vs edge yet)
    for (int i = 0; i < 8; i++) begin
      v = 24'($urandom);
      step(v, 1'b1, 1'b0, v);
    end
    idle(6);
    chk("identity_sat", 32'(sat_cnt_o), 32'd0);

    // C=96 (1.5), B=10
    contrast_i = 16'd96; brightness_i = 16'sd10;
    step(24'h0, 1'b0, 1'b1, 24'h0);
    step(24'hC80080, 1'b1, 1'b0, 24'hF6008A);   // 200->246, 0->0 clip, 128->138
    step(24'h808080, 1'b1, 1'b0, 24'h8A8A8A);
    step(24'h817F80, 1'b1, 1'b0, 24'h8C898A);   // rounding: 129->140, 127->137

    // New inputs mid-frame are ignored until the next vs rising edge
    contrast_i = 16'd0; brightness_i = -16'sd20;
    step(24'h808080, 1'b1, 1'b0, 24'h8A8A8A);
    step(24'h808080, 1'b1, 1'b1, 24'h8A8A8A);   // edge-cycle pixel: old values
    step(24'hFF004D, 1'b1, 1'b1, 24'h6C6C6C);   // C=0,B=-20 -> 108
    step(24'h0A141E, 1'b1, 1'b0, 24'h6C6C6C);
    idle(6);
    chk("sat_after_c96", 32'(sat_cnt_o), 32'd1);

    // Extreme gain and offset: no wrap before the clamp
    contrast_i = 16'hFFFF; brightness_i = -16'sd32768;
    step(24'h0, 1'b0, 1'b1, 24'h0);
    step(24'hFF0080, 1'b1, 1'b0, 24'hFF0000);
    step(24'h8180C8, 1'b1, 1'b0, 24'h0000FF);
    idle(6);
    chk("sat_after_c0", 32'(sat_cnt_o), 32'd0);

    // Clip-count frame, C=192 (3.0), B=127
    contrast_i = 16'd192; brightness_i = 16'sd127;
    step(24'h0, 1'b0, 1'b1, 24'h0);
    idle(6);
    chk("sat_after_cmax", 32'(sat_cnt_o), 32'd2);
    nclip = 0;
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 9) step(24'h0, 1'b0, 1'b0, 24'h0);  // blank data must not count
      if (i % 2 == 0 && nclip < 37) begin
        step(24'h646481, 1'b1, 1'b0, 24'hABABFF);       // 129 clips high
        nclip++;
      end else begin
        step(24'h802B64, 1'b1, 1'b0, 24'hFF00AB);       // 128->255, 43->0 exact
      end
    end
    bypass_i = 1'b1;
    step(24'h0, 1'b0, 1'b1, 24'h0);
    idle(6);
    chk("sat_37", 32'(sat_cnt_o), 32'd37);

    // Bypass frame: bit-exact passthrough, nothing counted
    step(24'h646481, 1'b1, 1'b0, 24'h646481);
    step(24'h000000, 1'b1, 1'b0, 24'h000000);
    step(24'hFFFFFF, 1'b1, 1'b0, 24'hFFFFFF);
    for (int i = 0; i < 4; i++) begin
      v = 24'($urandom);
      step(v, 1'b1, 1'b0, v);
    end
    bypass_i = 1'b0; contrast_i = 16'd96; brightness_i = 16'sd10;
    step(24'h0, 1'b0, 1'b1, 24'h0);
    idle(6);
    chk("sat_bypass", 32'(sat_cnt_o), 32'd0);

    // Build a nonzero count, then reset mid-frame
    step(24'hC80080, 1'b1, 1'b0, 24'hF6008A);
    step(24'hC80080, 1'b1, 1'b0, 24'hF6008A);
    step(24'h0, 1'b0, 1'b1, 24'h0);
    idle(6);
    chk("sat_pre_rst", 32'(sat_cnt_o), 32'd2);
    step(24'hC80080, 1'b1, 1'b0, 24'hF6008A);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(24'hC80080, 1'b1, 1'b0, 1'b0, 24'h0);     // lost to the reset
    end
    @(posedge clk); #1;
    rst = 1'b1;
    drive(24'hC80080, 1'b1, 1'b0, 1'b0, 24'h0);
    @(posedge clk); #1;
    chk("rst_mid_de", 32'(de_o), 32'd0);
    chk("rst_mid_sat", 32'(sat_cnt_o), 32'd0);
    chk("rst_mid_do", 32'(do_o), 32'd0);
    rst = 1'b0;
    drive(24'hC80080, 1'b1, 1'b1, 1'b1, 24'hC80080); // identity; edge right after reset
    step(24'hC80080, 1'b1, 1'b0, 24'hF6008A);       // loaded C=96,B=10
    idle(8);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
